// File: rtl/poker_types_pkg.sv
// Shared poker types and helpers for the showdown comparators.
// Cards are {suit, rank} with rank 2..14 (ace high); scores compare as {hand_type, hand_rank}.
package poker_types;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [3:0] {
        HIGH_CARD      = 4'd0,
        ONE_PAIR       = 4'd1,
        TWO_PAIR       = 4'd2,
        THREE_KIND     = 4'd3,
        STRAIGHT       = 4'd4,
        FLUSH          = 4'd5,
        FULL_HOUSE     = 4'd6,
        FOUR_KIND      = 4'd7,
        STRAIGHT_FLUSH = 4'd8
    } hand_type_t;

    typedef struct packed {
        hand_type_t  hand_type;
        logic [15:0] hand_rank;
    } score_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EVAL   = 2'd1,
        ST_REDUCE = 2'd2,
        ST_DONE   = 2'd3
    } cmp_state_t;

    localparam int NUM_COMBOS = 21;

    // Five indices into the 7-card array {hole0, hole1, comm0..comm4}, element 0 lowest.
    typedef logic [4:0][2:0] combo_t;
    localparam combo_t COMBO_FIRST = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};

    // Next 5-of-7 combination in lexicographic order; wraps to the first after {2,3,4,5,6}.
    function automatic combo_t combo_next(input combo_t c);
        combo_t     n;
        logic       found;
        logic [2:0] piv;
        found = 1'b0;
        piv   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (c[i] < 3'(i + 2)) begin
                found = 1'b1;
                piv   = 3'(i);
            end else begin
                piv   = piv;
            end
        end
        n = COMBO_FIRST;
        if (found) begin
            for (int j = 0; j < 5; j++) begin
                if (3'(j) < piv) n[j] = c[j];
                else             n[j] = c[piv] + 3'd1 + (3'(j) - piv);
            end
        end else begin
            n = COMBO_FIRST;
        end
        return n;
    endfunction

    function automatic logic score_gt(input score_t a, input score_t b);
        return {a.hand_type, a.hand_rank} > {b.hand_type, b.hand_rank};
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/multi_hand_comparator_eval.sv
// Five-card hand evaluator: classifies the hand and registers its score one cycle later.
// Rank encoding: straights by top card, grouped hands by group ranks then kickers, flush/high card by rank bitmap.
module hand_eval_5card
    import poker_types::*;
(
    input  logic   clk,
    input  logic   reset,
    input  card_t  cards [5],
    output score_t score
);

    logic [2:0]  cnt_s [13];
    logic [12:0] mask_s;
    logic        flush_s;
    logic        straight_s;
    logic [3:0]  top_s;
    logic [3:0]  quad_s;
    logic [3:0]  trips_s;
    logic [3:0]  pair_hi_s;
    logic [3:0]  pair_lo_s;
    logic [1:0]  npair_s;
    logic [2:0]  nsingle_s;
    logic [3:0]  kick_s [3];
    score_t      score_s;

    // Rank histogram, rank bitmap and flush detection.
    always_comb begin
        for (int r = 0; r < 13; r++) cnt_s[r] = 3'd0;
        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < 13; r++) begin
                if (cards[i].rank == 4'(r + 2)) cnt_s[r] = cnt_s[r] + 3'd1;
                else                            cnt_s[r] = cnt_s[r];
            end
        end
        for (int r = 0; r < 13; r++) mask_s[r] = (cnt_s[r] != 3'd0);
        flush_s = 1'b1;
        for (int i = 1; i < 5; i++) flush_s = flush_s & (cards[i].suit == cards[0].suit);
    end

    // Straight detection; the ace-low wheel tops out at five.
    always_comb begin
        straight_s = (mask_s == 13'b1_0000_0000_1111);
        top_s      = straight_s ? 4'd5 : 4'd0;
        for (int t = 4; t < 13; t++) begin
            if (mask_s[t -: 5] == 5'b11111) begin
                straight_s = 1'b1;
                top_s      = 4'(t + 2);
            end else begin
                top_s      = top_s;
            end
        end
    end

    // Group ranks and descending kickers, scanning from ace down.
    always_comb begin
        quad_s    = 4'd0;
        trips_s   = 4'd0;
        pair_hi_s = 4'd0;
        pair_lo_s = 4'd0;
        npair_s   = 2'd0;
        nsingle_s = 3'd0;
        for (int k = 0; k < 3; k++) kick_s[k] = 4'd0;
        for (int r = 12; r >= 0; r--) begin
            case (cnt_s[r])
                3'd4: quad_s  = 4'(r + 2);
                3'd3: trips_s = 4'(r + 2);
                3'd2: begin
                    if (npair_s == 2'd0) pair_hi_s = 4'(r + 2);
                    else                 pair_lo_s = 4'(r + 2);
                    npair_s = npair_s + 2'd1;
                end
                3'd1: begin
                    for (int k = 0; k < 3; k++) begin
                        if (nsingle_s == 3'(k)) kick_s[k] = 4'(r + 2);
                        else                    kick_s[k] = kick_s[k];
                    end
                    nsingle_s = nsingle_s + 3'd1;
                end
                default: nsingle_s = nsingle_s;
            endcase
        end
    end

    // Hand classification, strongest category first.
    always_comb begin
        score_s.hand_type = HIGH_CARD;
        score_s.hand_rank = {3'd0, mask_s};
        if (straight_s && flush_s) begin
            score_s.hand_type = STRAIGHT_FLUSH;
            score_s.hand_rank = {12'd0, top_s};
        end else if (quad_s != 4'd0) begin
            score_s.hand_type = FOUR_KIND;
            score_s.hand_rank = {8'd0, quad_s, kick_s[0]};
        end else if ((trips_s != 4'd0) && (npair_s != 2'd0)) begin
            score_s.hand_type = FULL_HOUSE;
            score_s.hand_rank = {8'd0, trips_s, pair_hi_s};
        end else if (flush_s) begin
            score_s.hand_type = FLUSH;
            score_s.hand_rank = {3'd0, mask_s};
        end else if (straight_s) begin
            score_s.hand_type = STRAIGHT;
            score_s.hand_rank = {12'd0, top_s};
        end else if (trips_s != 4'd0) begin
            score_s.hand_type = THREE_KIND;
            score_s.hand_rank = {4'd0, trips_s, kick_s[0], kick_s[1]};
        end else if (npair_s == 2'd2) begin
            score_s.hand_type = TWO_PAIR;
            score_s.hand_rank = {4'd0, pair_hi_s, pair_lo_s, kick_s[0]};
        end else if (npair_s == 2'd1) begin
            score_s.hand_type = ONE_PAIR;
            score_s.hand_rank = {pair_hi_s, kick_s[0], kick_s[1], kick_s[2]};
        end else begin
            score_s.hand_type = HIGH_CARD;
            score_s.hand_rank = {3'd0, mask_s};
        end
    end

    // Result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) score <= '0;
        else       score <= score_s;
    end

endmodule

// File: rtl/multi_hand_comparator.sv
// N-player showdown: sweeps all 21 five-of-seven combinations per seat, keeps each seat's best
// score, then reduces across active seats to a winner mask with split pots on ties.
module multi_hand_comparator
    import poker_types::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int CNT_W       = $clog2(NUM_PLAYERS + 1)
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  card_t                  hole [NUM_PLAYERS][2],
    input  card_t                  community [5],
    input  logic [NUM_PLAYERS-1:0] active,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_PLAYERS-1:0] winner_mask,
    output logic [CNT_W-1:0]       num_winners,
    output hand_type_t             win_type,
    output logic [15:0]            win_rank,
    output logic                   no_contest
);

    cmp_state_t             state_r, state_s;
    card_t                  hole_r [NUM_PLAYERS][2];
    card_t                  comm_r [5];
    logic [NUM_PLAYERS-1:0] active_r;
    combo_t                 combo_r;
    logic [4:0]             combo_idx_r;
    logic                   eval_valid_r;
    score_t                 best_r  [NUM_PLAYERS];
    score_t                 score_s [NUM_PLAYERS];
    score_t                 max_s;
    logic [NUM_PLAYERS-1:0] mask_s;
    logic                   accept_s;
    logic                   eval_reset_s;

    assign eval_reset_s = ~reset;
    assign accept_s     = (state_r == ST_IDLE) && in_valid && in_ready;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_seat
        card_t seven_s [7];
        card_t pick_s  [5];

        // Present the current combination of this seat's seven cards.
        always_comb begin
            seven_s[0] = hole_r[p][0];
            seven_s[1] = hole_r[p][1];
            for (int i = 0; i < 5; i++) seven_s[i + 2] = comm_r[i];
            for (int i = 0; i < 5; i++) pick_s[i] = seven_s[combo_r[i]];
        end

        hand_eval_5card u_eval (
            .clk   (clk),
            .reset (eval_reset_s),
            .cards (pick_s),
            .score (score_s[p])
        );
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = accept_s ? ST_EVAL : ST_IDLE;
            ST_EVAL:   state_s = (combo_idx_r == 5'(NUM_COMBOS)) ? ST_REDUCE : ST_EVAL;
            ST_REDUCE: state_s = ST_DONE;
            ST_DONE:   state_s = (out_valid && out_ready) ? ST_IDLE : ST_DONE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Winner reduction over active seats; an empty table leaves max at zero.
    always_comb begin
        max_s = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (active_r[p] && score_gt(best_r[p], max_s)) max_s = best_r[p];
            else                                           max_s = max_s;
        end
        for (int p = 0; p < NUM_PLAYERS; p++) mask_s[p] = active_r[p] && (best_r[p] == max_s);
    end

    // State register and ready flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            in_ready <= 1'b1;
        end else begin
            state_r  <= state_s;
            in_ready <= (state_s == ST_IDLE);
        end
    end

    // Request capture, combination sweep and per-seat best-score tracking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                hole_r[p][0] <= '0;
                hole_r[p][1] <= '0;
                best_r[p]    <= '0;
            end
            for (int i = 0; i < 5; i++) comm_r[i] <= '0;
            active_r     <= '0;
            combo_r      <= COMBO_FIRST;
            combo_idx_r  <= 5'd0;
            eval_valid_r <= 1'b0;
        end else if (accept_s) begin
            hole_r       <= hole;
            comm_r       <= community;
            active_r     <= active;
            combo_r      <= COMBO_FIRST;
            combo_idx_r  <= 5'd0;
            eval_valid_r <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) best_r[p] <= '0;
        end else if (state_r == ST_EVAL) begin
            combo_r      <= combo_next(combo_r);
            combo_idx_r  <= combo_idx_r + 5'd1;
            eval_valid_r <= (combo_idx_r != 5'(NUM_COMBOS));
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (eval_valid_r && score_gt(score_s[p], best_r[p])) best_r[p] <= score_s[p];
                else                                                 best_r[p] <= best_r[p];
            end
        end else begin
            eval_valid_r <= 1'b0;
        end
    end

    // Result registers, held through backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid   <= 1'b0;
            no_contest  <= 1'b0;
            winner_mask <= '0;
            num_winners <= '0;
            win_type    <= HIGH_CARD;
            win_rank    <= 16'd0;
        end else if (state_r == ST_REDUCE) begin
            out_valid   <= 1'b1;
            no_contest  <= (active_r == '0);
            winner_mask <= mask_s;
            num_winners <= CNT_W'(popcount8(8'(mask_s)));
            win_type    <= max_s.hand_type;
            win_rank    <= max_s.hand_rank;
        end else if ((state_r == ST_DONE) && out_ready) begin
            out_valid   <= 1'b0;
        end else begin
            out_valid   <= out_valid;
        end
    end

endmodule
